// File: rtl/clk_mon_pkg.sv
// ============================================================================
// Module      : clk_mon_pkg
// Description : Shared types and constants for the divided-clock phase monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_mon_pkg;

    localparam int PHASE_W = 3;
    localparam int ERR_W   = 8;
    localparam int CNT_W   = 4;

    localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Expected successor of a sampled phase; 3-bit arithmetic wraps both ways.
    function automatic logic [PHASE_W-1:0] next_phase(
        input logic [PHASE_W-1:0] v,
        input logic               down
    );
        return down ? (v - 3'd1) : (v + 3'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that holds at MAX_VAL, with clear and sync reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_VAL)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// ============================================================================
// Module      : clk_div_monitor
// Description : Samples {clkf,clk2f,clk4f} on clk8f and verifies the phase
//               advances one step per cycle; reports lock and step errors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int LOCK_CNT   = 8,
    parameter int LOSS_CNT   = 2,
    parameter int COUNT_DOWN = 0
) (
    input  logic               clk8f,
    input  logic               reset,
    input  logic               clkf,
    input  logic               clk2f,
    input  logic               clk4f,
    output logic               locked,
    output logic               err_pulse,
    output logic [ERR_W-1:0]   err_count,
    output logic [PHASE_W-1:0] phase
);

    localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] LOSS_TGT = CNT_W'(LOSS_CNT);
    localparam logic             DOWN     = (COUNT_DOWN != 0);

    logic [PHASE_W-1:0] s_q;
    logic [PHASE_W-1:0] p_q;
    logic               sv_q;
    logic               pv_q;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   good_cnt_q,  good_cnt_d;
    logic [CNT_W-1:0]   bad_cnt_q,   bad_cnt_d;
    logic               err_pulse_q, err_pulse_d;
    logic [PHASE_W-1:0] phase_q,     phase_d;
    logic               w_err_inc;
    logic               w_step_ok;

    // sv_q marks s_q as loaded; pv_q follows it so p_q is valid one edge later.
    always_ff @(posedge clk8f) begin
        if (reset) begin
            s_q  <= '0;
            p_q  <= '0;
            sv_q <= 1'b0;
            pv_q <= 1'b0;
        end else begin
            s_q  <= {clkf, clk2f, clk4f};
            p_q  <= s_q;
            sv_q <= 1'b1;
            pv_q <= sv_q;
        end
    end

    assign w_step_ok = pv_q && (s_q == next_phase(p_q, DOWN));

    always_ff @(posedge clk8f) begin
        if (reset) begin
            state_q     <= IDLE;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
            phase_q     <= '0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            err_pulse_q <= err_pulse_d;
            phase_q     <= phase_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        err_pulse_d = 1'b0;
        w_err_inc   = 1'b0;

        case (state_q)
            // IDLE judges the very first valid step exactly as ACQUIRE does,
            // so lock lands LOCK_CNT edges after the first step is evaluated.
            IDLE, ACQUIRE: begin
                if (pv_q) begin
                    if (w_step_ok) begin
                        if ((good_cnt_q + 1'b1) == LOCK_TGT) begin
                            state_d    = LOCKED;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end else begin
                            state_d    = ACQUIRE;
                            good_cnt_d = good_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d     = ACQUIRE;
                        good_cnt_d  = '0;
                        err_pulse_d = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (w_step_ok) begin
                    bad_cnt_d = '0;
                end else begin
                    err_pulse_d = 1'b1;
                    w_err_inc   = 1'b1;
                    if ((bad_cnt_q + 1'b1) == LOSS_TGT) begin
                        state_d    = ACQUIRE;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                good_cnt_d = '0;
                bad_cnt_d  = '0;
            end
        endcase

        phase_d = (state_d == LOCKED) ? s_q : '0;
    end

    sat_counter #(
        .WIDTH   (ERR_W),
        .MAX_VAL (ERR_MAX)
    ) u_err_cnt (
        .clk_i   (clk8f),
        .rst_i   (reset),
        .clr_i   (1'b0),
        .inc_i   (w_err_inc),
        .count_o (err_count)
    );

    assign locked    = (state_q == LOCKED);
    assign err_pulse = err_pulse_q;
    assign phase     = phase_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
// ============================================================================
// Module      : tb_clk_div_monitor
// Description : Self-checking bench for clk_div_monitor, three configurations
//               driven from one shared stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_clk_div_monitor;

    logic clk8f = 1'b0;
    always #5 clk8f = ~clk8f;

    logic       reset;
    logic       clkf, clk2f, clk4f;
    logic       lk_a, ep_a, lk_d, ep_d, lk_s, ep_s;
    logic [7:0] ec_a, ec_d, ec_s;
    logic [2:0] ph_a, ph_d, ph_s;

    // a: defaults; d: counts down; s: LOSS_CNT=15
    clk_div_monitor #(.LOCK_CNT(8), .LOSS_CNT(2), .COUNT_DOWN(0)) dut_a (
        .clk8f(clk8f), .reset(reset), .clkf(clkf), .clk2f(clk2f), .clk4f(clk4f),
        .locked(lk_a), .err_pulse(ep_a), .err_count(ec_a), .phase(ph_a));
    clk_div_monitor #(.LOCK_CNT(8), .LOSS_CNT(2), .COUNT_DOWN(1)) dut_d (
        .clk8f(clk8f), .reset(reset), .clkf(clkf), .clk2f(clk2f), .clk4f(clk4f),
        .locked(lk_d), .err_pulse(ep_d), .err_count(ec_d), .phase(ph_d));
    clk_div_monitor #(.LOCK_CNT(8), .LOSS_CNT(15), .COUNT_DOWN(0)) dut_s (
        .clk8f(clk8f), .reset(reset), .clkf(clkf), .clk2f(clk2f), .clk4f(clk4f),
        .locked(lk_s), .err_pulse(ep_s), .err_count(ec_s), .phase(ph_s));

    typedef struct packed {
        logic       lk;
        logic       ep;
        logic [7:0] ec;
        logic [2:0] ph;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t d;
        obs_t s;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    obs_t act_a, act_d, act_s;
    assign act_a = {lk_a, ep_a, ec_a, ph_a};
    assign act_d = {lk_d, ep_d, ec_d, ph_d};
    assign act_s = {lk_s, ep_s, ec_s, ph_s};

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] v_last;

    // Reference model state, one slot per instance (0=a, 1=d, 2=s).
    logic [2:0] m_s[3], m_p[3], m_ph[3];
    logic       m_sv[3], m_pv[3], m_ep[3];
    int         m_st[3], m_g[3], m_b[3], m_ec[3];

    function automatic int p_loss(int i);
        return (i == 2) ? 15 : 2;
    endfunction

    function automatic obs_t mk(int i);
        obs_t o;
        o.lk = (m_st[i] == 2);
        o.ep = m_ep[i];
        o.ec = 8'(m_ec[i]);
        o.ph = m_ph[i];
        return o;
    endfunction

    task automatic model_step(input logic rst, input logic [2:0] v);
        logic [2:0] want;
        logic       ok;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_s[i] = 0; m_p[i] = 0; m_sv[i] = 0; m_pv[i] = 0; m_ph[i] = 0;
                m_ep[i] = 0; m_st[i] = 0; m_g[i] = 0; m_b[i] = 0; m_ec[i] = 0;
            end else begin
                want = (i == 1) ? m_p[i] - 3'd1 : m_p[i] + 3'd1;
                ok = m_pv[i] && (m_s[i] == want);
                m_ep[i] = 0;
                if (m_st[i] == 2) begin
                    if (ok) m_b[i] = 0;
                    else begin
                        m_ep[i] = 1;
                        if (m_ec[i] < 255) m_ec[i]++;
                        m_b[i]++;
                        if (m_b[i] == p_loss(i)) begin m_st[i] = 1; m_g[i] = 0; m_b[i] = 0; end
                    end
                end else if (m_pv[i]) begin
                    m_st[i] = 1;
                    if (ok) begin
                        m_g[i]++;
                        if (m_g[i] == 8) begin m_st[i] = 2; m_g[i] = 0; m_b[i] = 0; end
                    end else begin
                        m_g[i] = 0;
                        m_ep[i] = 1;
                    end
                end
                m_ph[i] = (m_st[i] == 2) ? m_s[i] : 3'd0;
                m_pv[i] = m_sv[i];
                m_p[i]  = m_s[i];
                m_sv[i] = 1;
                m_s[i]  = v;
            end
        end
    endtask

    // Drive one cycle at a falling edge, queue the expected post-edge outputs,
    // and return at the next falling edge.
    task automatic tick(input logic rst, input logic [2:0] v);
        exp_t e;
        reset = rst;
        {clkf, clk2f, clk4f} = v;
        v_last = v;
        model_step(rst, v);
        e.a = mk(0);
        e.d = mk(1);
        e.s = mk(2);
        sb.push_back(e);
        @(negedge clk8f);
    endtask

    always @(posedge clk8f) begin
        #1;
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            n_vec++;
            if (act_a !== e_mon.a) begin
                n_err++;
                $display("FAIL sb_a t=%0t: got %h want %h", $time, act_a, e_mon.a);
            end
            n_vec++;
            if (act_d !== e_mon.d) begin
                n_err++;
                $display("FAIL sb_d t=%0t: got %h want %h", $time, act_d, e_mon.d);
            end
            n_vec++;
            if (act_s !== e_mon.s) begin
                n_err++;
                $display("FAIL sb_s t=%0t: got %h want %h", $time, act_s, e_mon.s);
            end
        end
    end

    task automatic test_reset();
        tick(1'b1, 3'd5);
        tick(1'b1, 3'd2);
        n_vec++;
        if ({act_a, act_d, act_s} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got %h %h %h want all 0", act_a, act_d, act_s);
        end
    endtask

    task automatic test_ideal_up();
        tick(1'b1, 3'd0);
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 3'(k - 1));
            n_vec++;
            if (lk_a !== (k >= 10)) begin
                n_err++;
                $display("FAIL ideal_lock E%0d: locked=%b want %b", k, lk_a, (k >= 10));
            end
            n_vec++;
            if (ep_a !== 1'b0 || lk_d !== 1'b0) begin
                n_err++;
                $display("FAIL ideal_clean E%0d: err_pulse=%b locked_d=%b want 0 0", k, ep_a, lk_d);
            end
            if (k >= 10) begin
                n_vec++;
                if (ph_a !== 3'(k - 2)) begin
                    n_err++;
                    $display("FAIL ideal_phase E%0d: phase=%0d want %0d", k, ph_a, 3'(k - 2));
                end
            end
        end
    endtask

    task automatic test_single_slip();
        logic [2:0] nv;
        nv = v_last + 3'd2;
        tick(1'b0, nv);
        n_vec++;
        if (ep_a !== 1'b0) begin
            n_err++;
            $display("FAIL slip_early: err_pulse=%b want 0", ep_a);
        end
        nv = nv + 3'd1;
        tick(1'b0, nv);
        n_vec++;
        if ({lk_a, ep_a, ec_a} !== {1'b1, 1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL slip_err: locked=%b err_pulse=%b err_count=%0d want 1 1 1", lk_a, ep_a, ec_a);
        end
        nv = nv + 3'd1;
        tick(1'b0, nv);
        n_vec++;
        if ({lk_a, ep_a, ec_a} !== {1'b1, 1'b0, 8'd1}) begin
            n_err++;
            $display("FAIL slip_after: locked=%b err_pulse=%b err_count=%0d want 1 0 1", lk_a, ep_a, ec_a);
        end
    endtask

    task automatic test_loss_relock();
        logic [2:0] nv;
        nv = v_last + 3'd1;
        tick(1'b0, nv ^ 3'd1);
        n_vec++;
        if (ep_a !== 1'b0 || lk_a !== 1'b1) begin
            n_err++;
            $display("FAIL loss_t0: err_pulse=%b locked=%b want 0 1", ep_a, lk_a);
        end
        for (int t = 1; t <= 12; t++) begin
            nv = nv + 3'd1;
            tick(1'b0, nv);
            if (t == 1) begin
                n_vec++;
                if ({lk_a, ep_a, ec_a} !== {1'b1, 1'b1, 8'd2}) begin
                    n_err++;
                    $display("FAIL loss_first: locked=%b err_pulse=%b err_count=%0d want 1 1 2", lk_a, ep_a, ec_a);
                end
            end
            if (t == 2) begin
                n_vec++;
                if ({lk_a, ep_a, ec_a, ph_a} !== {1'b0, 1'b1, 8'd3, 3'd0}) begin
                    n_err++;
                    $display("FAIL loss_drop: locked=%b err_pulse=%b err_count=%0d phase=%0d want 0 1 3 0",
                             lk_a, ep_a, ec_a, ph_a);
                end
            end
            if (t == 9 || t == 10) begin
                n_vec++;
                if (lk_a !== (t == 10)) begin
                    n_err++;
                    $display("FAIL relock t%0d: locked=%b want %b", t, lk_a, (t == 10));
                end
            end
        end
    endtask

    task automatic test_stuck_zero();
        tick(1'b1, 3'd0);
        n_vec++;
        if ({lk_a, ep_a, ec_a, ph_a} !== '0) begin
            n_err++;
            $display("FAIL reset_midlock_a: got %h want 0", act_a);
        end
        for (int k = 1; k <= 12; k++) begin
            tick(1'b0, 3'd0);
            n_vec++;
            if ({lk_a, ep_a, ec_a} !== {1'b0, (k >= 3), 8'd0}) begin
                n_err++;
                $display("FAIL stuck E%0d: locked=%b err_pulse=%b err_count=%0d want 0 %b 0",
                         k, lk_a, ep_a, ec_a, (k >= 3));
            end
        end
    endtask

    task automatic test_count_down();
        tick(1'b1, 3'd0);
        for (int k = 1; k <= 20; k++) begin
            tick(1'b0, 3'(8 - k));
            n_vec++;
            if (lk_d !== (k >= 10) || ep_d !== 1'b0 || lk_a !== 1'b0) begin
                n_err++;
                $display("FAIL down E%0d: locked_d=%b err_pulse_d=%b locked_a=%b want %b 0 0",
                         k, lk_d, ep_d, lk_a, (k >= 10));
            end
            if (k >= 10) begin
                n_vec++;
                if (ph_d !== 3'(9 - k)) begin
                    n_err++;
                    $display("FAIL down_phase E%0d: phase=%0d want %0d", k, ph_d, 3'(9 - k));
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] nv;
        tick(1'b1, 3'd0);
        for (int k = 1; k <= 12; k++) tick(1'b0, 3'(k - 1));
        n_vec++;
        if (lk_s !== 1'b1) begin
            n_err++;
            $display("FAIL sat_lock: locked=%b want 1", lk_s);
        end
        nv = v_last;
        for (int blk = 0; blk < 24; blk++) begin
            repeat (13) tick(1'b0, nv);
            nv = nv + 3'd1;
            tick(1'b0, nv);
            if (blk == 0) begin
                n_vec++;
                if ({lk_s, ec_s} !== {1'b1, 8'd13}) begin
                    n_err++;
                    $display("FAIL sat_block0: locked=%b err_count=%0d want 1 13", lk_s, ec_s);
                end
            end
        end
        n_vec++;
        if ({lk_s, ec_s} !== {1'b1, 8'd255}) begin
            n_err++;
            $display("FAIL sat_full: locked=%b err_count=%0d want 1 255", lk_s, ec_s);
        end
        tick(1'b1, nv + 3'd1);
        n_vec++;
        if ({act_s, act_a} !== '0) begin
            n_err++;
            $display("FAIL sat_reset: got %h %h want 0 0", act_s, act_a);
        end
    endtask

    initial begin
        reset = 1'b1;
        {clkf, clk2f, clk4f} = 3'd0;
        v_last = 3'd0;
        @(negedge clk8f);
        test_reset();
        test_ideal_up();
        test_single_slip();
        test_loss_relock();
        test_stuck_zero();
        test_count_down();
        test_saturation();
        tick(1'b0, 3'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
